// File: rtl/stop_watch_disp.sv
// rtl/stop_watch_disp.sv - four-digit multiplexed seven-segment display for a stopwatch (SS.CC).
// Optional macro STOP_WATCH_DISP_BLANK_EN blanks a leading zero in the seconds-tens slot.
module stop_watch_disp #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] centisec,
  input  logic [5:0] sec,
  input  logic       freezing,
  output logic [7:0] seg,
  output logic [3:0] dig_sel
);

  localparam logic [15:0] SCAN_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [15:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]  dig_idx_q, dig_idx_d;
  logic [6:0]  snap_cs_q, snap_cs_d;
  logic [5:0]  snap_sec_q, snap_sec_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        blink_q, blink_d;
  logic [7:0]  seg_q, seg_d;
  logic [3:0]  dig_sel_q, dig_sel_d;

  logic        frame_end;
  logic        cs_valid, sec_valid;
  logic [3:0]  cs_ones, cs_tens, sec_ones, sec_tens;
  logic [3:0]  digit;
  logic        digit_valid;
  logic        dp_n;

  // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign frame_end = (dig_idx_q == 2'd3) && (scan_cnt_q == SCAN_LAST);

  always_comb begin
    scan_cnt_d  = scan_cnt_q + 16'd1;
    dig_idx_d   = dig_idx_q;
    snap_cs_d   = snap_cs_q;
    snap_sec_d  = snap_sec_q;
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;

    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = 16'd0;
      dig_idx_d  = dig_idx_q + 2'd1;
    end

    // Snapshot and blink state only move on frame boundaries so a frame is self-consistent.
    if (frame_end) begin
      snap_cs_d  = centisec;
      snap_sec_d = sec;
      if (freezing) begin
        if (frame_cnt_q == BLINK_LAST) begin
          frame_cnt_d = 8'd0;
          blink_d     = ~blink_q;
        end else begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end else begin
        frame_cnt_d = 8'd0;
        blink_d     = 1'b0;
      end
    end
  end

  always_comb begin
    cs_valid  = (snap_cs_q <= 7'd99);
    sec_valid = (snap_sec_q <= 6'd59);
    cs_tens   = 4'(snap_cs_q / 7'd10);
    cs_ones   = 4'(snap_cs_q % 7'd10);
    sec_tens  = 4'(snap_sec_q / 6'd10);
    sec_ones  = 4'(snap_sec_q % 6'd10);

    digit       = 4'd0;
    digit_valid = 1'b1;
    case (dig_idx_q)
      2'd0: begin digit = cs_ones;  digit_valid = cs_valid;  end
      2'd1: begin digit = cs_tens;  digit_valid = cs_valid;  end
      2'd2: begin digit = sec_ones; digit_valid = sec_valid; end
      default: begin digit = sec_tens; digit_valid = sec_valid; end
    endcase

    dp_n      = !((dig_idx_q == 2'd2) && !blink_q);
    seg_d     = {dp_n, digit_valid ? seg7(digit) : 7'h3F};
    dig_sel_d = ~(4'b0001 << dig_idx_q);

`ifdef STOP_WATCH_DISP_BLANK_EN
    if ((dig_idx_q == 2'd3) && sec_valid && (sec_tens == 4'd0)) begin
      seg_d     = 8'hFF;
      dig_sel_d = 4'hF;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q  <= 16'd0;
      dig_idx_q   <= 2'd0;
      snap_cs_q   <= 7'd0;
      snap_sec_q  <= 6'd0;
      frame_cnt_q <= 8'd0;
      blink_q     <= 1'b0;
      seg_q       <= 8'hFF;
      dig_sel_q   <= 4'hF;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      dig_idx_q   <= dig_idx_d;
      snap_cs_q   <= snap_cs_d;
      snap_sec_q  <= snap_sec_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
      seg_q       <= seg_d;
      dig_sel_q   <= dig_sel_d;
    end
  end

  assign seg     = seg_q;
  assign dig_sel = dig_sel_q;

endmodule
